// File: rtl/neuron_pkg.sv
// Constants and helpers shared by the neuron datapath. The saturating add is sized for the
// widest legal accumulator, and the live accumulator width is passed in at each call.
package neuron_pkg;
  localparam int GUARD_BITS = 8;
  localparam int ACT_ONE    = 1;
  localparam int ACT_ZERO   = 0;

  // Widest accumulator supported: WIDTH=32 -> 2*32+8.
  localparam int SAT_MAX_W = 2*32 + GUARD_BITS;
  typedef logic signed [SAT_MAX_W-1:0] sat_t;

  // Sign-extended a+b, clamped to the signed range of a w-bit accumulator.
  function automatic sat_t sat_add(input sat_t a, input sat_t b, input int unsigned w);
    logic signed [SAT_MAX_W:0] s, one, lim, hi, lo;
    sat_t r;
    one = {{SAT_MAX_W{1'b0}}, 1'b1};
    s   = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
    lim = one << (w - 1);
    hi  = lim - one;
    lo  = -lim;
    if (s > hi)      r = hi[SAT_MAX_W-1:0];
    else if (s < lo) r = lo[SAT_MAX_W-1:0];
    else             r = s[SAT_MAX_W-1:0];
    return r;
  endfunction
endpackage

// File: rtl/neuron_mac.sv
// Multiply-accumulate core: full-precision signed product folded into a saturating
// accumulator register.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter  int WIDTH     = 8,
  localparam int ACC_WIDTH = 2*WIDTH + GUARD_BITS
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic signed [WIDTH-1:0]     i_w,
  input  logic signed [WIDTH-1:0]     i_x,
  output logic signed [ACC_WIDTH-1:0] o_acc
);
  logic signed [2*WIDTH-1:0]   w_prod;
  sat_t                        w_prod_ext, w_acc_ext, w_sum;
  logic signed [ACC_WIDTH-1:0] r_acc;

  // Operands widened first so the product keeps every bit.
  assign w_prod     = $signed({{WIDTH{i_w[WIDTH-1]}}, i_w}) *
                      $signed({{WIDTH{i_x[WIDTH-1]}}, i_x});
  assign w_prod_ext = sat_t'(w_prod);
  assign w_acc_ext  = sat_t'(r_acc);
  assign w_sum      = sat_add(w_acc_ext, w_prod_ext, ACC_WIDTH);

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_acc <= '0;
    else if (i_en) r_acc <= w_sum[ACC_WIDTH-1:0];
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/neuron_nbits.sv
// Single neuron: saturating MAC followed by a registered step activation (Out is 0 or 1,
// and lags the accumulator by one edge).
module neuron_nbits
  import neuron_pkg::*;
#(
  parameter  int WIDTH     = 8,
  localparam int ACC_WIDTH = 2*WIDTH + GUARD_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] W,
  input  logic signed [WIDTH-1:0] X,
  output logic signed [WIDTH-1:0] Out
);
  logic signed [ACC_WIDTH-1:0] w_acc;
  logic                        w_act;
  logic signed [WIDTH-1:0]     r_out;

  neuron_mac #(.WIDTH(WIDTH)) u_mac (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (en),
    .i_w   (W),
    .i_x   (X),
    .o_acc (w_acc)
  );

  // Strictly positive: sign clear and not zero.
  assign w_act = !w_acc[ACC_WIDTH-1] && (w_acc != '0);

  always_ff @(posedge clk) begin
    if (rst) r_out <= WIDTH'(ACT_ZERO);
    else     r_out <= w_act ? WIDTH'(ACT_ONE) : WIDTH'(ACT_ZERO);
  end

  assign Out = r_out;
endmodule

// File: tb/tb_neuron_nbits.sv
// Scoreboarded bench for neuron_nbits (WIDTH=8): directed scenarios plus random traffic
// checked against an integer reference model.
module tb_neuron_nbits;
  localparam int WIDTH   = 8;
  localparam int ACC_W   = 2*WIDTH + 8;
  localparam longint AMAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (ACC_W-1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic signed [WIDTH-1:0] W = '0;
  logic signed [WIDTH-1:0] X = '0;
  logic signed [WIDTH-1:0] Out;

  typedef struct {
    logic signed [WIDTH-1:0] out;
    logic signed [ACC_W-1:0] acc;
  } exp_t;

  exp_t   sb[$];
  longint mdl_acc = 0;
  int     n_pass = 0, n_total = 0;

  neuron_nbits #(.WIDTH(WIDTH)) dut (
    .clk (clk), .rst (rst), .en (en), .W (W), .X (X), .Out (Out)
  );

  always #5 clk = ~clk;

  // Drive one edge's worth of inputs and record what the design must show after it.
  task automatic step(input logic r, input logic e, input int w, input int x);
    exp_t   ex;
    longint p;
    @(negedge clk);
    rst = r; en = e; W = WIDTH'(w); X = WIDTH'(x);
    if (r) begin
      ex.out  = '0;
      mdl_acc = 0;
    end else begin
      ex.out = (mdl_acc > 0) ? WIDTH'(1) : WIDTH'(0);
      if (e) begin
        p = longint'(W) * longint'(X);
        mdl_acc = mdl_acc + p;
        if (mdl_acc > AMAX) mdl_acc = AMAX;
        if (mdl_acc < AMIN) mdl_acc = AMIN;
      end
    end
    ex.acc = ACC_W'(mdl_acc);
    sb.push_back(ex);
  endtask

  always @(posedge clk) begin
    exp_t ex;
    #1;
    if (sb.size() > 0) begin
      ex = sb.pop_front();
      n_total++;
      if (Out === ex.out) n_pass++;
      else $display("FAIL out: got %0d want %0d at %0t", Out, ex.out, $time);
      n_total++;
      if (dut.u_mac.o_acc === ex.acc) n_pass++;
      else $display("FAIL acc: got %0d want %0d at %0t", dut.u_mac.o_acc, ex.acc, $time);
    end
  end

  function automatic int pick();
    case ($urandom_range(0, 3))
      0:       return -128;
      1:       return 127;
      default: return int'($signed(8'($urandom)));
    endcase
  endfunction

  initial begin
    // Negative accumulation.
    step(1, 0, 0, 0);
    step(0, 1, -3, 2);
    step(0, 1, 5, -4);
    // Mid-operation reset, then a zero product.
    step(1, 1, 7, 7);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    // Positive accumulation with activation latency.
    step(0, 1, 64, 2);
    step(0, 1, 64, 2);
    // Enable held low: inputs ignored.
    repeat (3) step(0, 0, 8, 4);
    // Positive saturation.
    repeat (530) step(0, 1, -128, -128);
    // Negative saturation from the positive limit.
    repeat (1100) step(0, 1, -128, 127);
    // Zero boundary.
    step(1, 0, 0, 0);
    step(0, 1, 1, 1);
    step(0, 1, -1, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Random traffic with occasional resets and extreme operands.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, pick(), pick());
    step(0, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expected outputs never compared, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/neuron_nbits.md
NEURON_NBITS -- requirements
Module: neuron_nbits

Interface
- REQ-001 SHALL have parameter WIDTH, default 8, giving the signed operand and output width in bits (legal 2..32).
- REQ-002 SHALL have localparam ACC_WIDTH = 2*WIDTH+8, the signed accumulator width (8 guard bits).
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
- REQ-005 SHALL have port en, input, 1 bit: accumulate enable.
- REQ-006 SHALL have port W, input, WIDTH bits, signed two's complement: weight.
- REQ-007 SHALL have port X, input, WIDTH bits, signed two's complement: input sample.
- REQ-008 SHALL have port Out, output, WIDTH bits, signed: registered activation result, only ever 0 or 1.

Function
- REQ-009 SHALL form the product P = W*X as a full-precision signed 2*WIDTH-bit value, sign-extended to ACC_WIDTH.
- REQ-010 SHALL, on a rising edge with rst=0 and en=1, update acc <= sat(acc + P).
- REQ-011 SHALL, on a rising edge with rst=0 and en=0, hold acc; W and X are then don't-care.
- REQ-012 SHALL saturate the sum at the signed ACC_WIDTH limits (max 2^(ACC_WIDTH-1)-1, min -2^(ACC_WIDTH-1)) and never wrap.
- REQ-013 SHALL apply a step activation: act = 1 when acc > 0; act = 0 when acc <= 0 (zero maps to 0).
- REQ-014 SHALL register act into Out on every rising edge with rst=0, regardless of en.
- REQ-015 SHALL therefore give Out a latency of one cycle after acc: a product accumulated at edge k is first reflected in Out after edge k+1.
- REQ-016 SHALL give rst priority over en when both are high: reset wins and no accumulation occurs on that edge.
- REQ-017 SHALL produce no combinational path from W, X or en to Out.

Reset
- REQ-018 SHALL, on a rising edge with rst=1, clear acc to 0 and Out to 0.
- REQ-019 SHALL honour reset mid-accumulation: the partial sum is discarded, and accumulation restarts from 0 on the first enabled edge after rst returns to 0.
- REQ-020 SHALL not reset asynchronously; before the first reset edge, acc and Out are undefined.

Structure
- REQ-021 SHALL place the guard-bit count (8), the activation output constants ACT_ONE = 1 and ACT_ZERO = 0, and the saturating-add function in a shared package neuron_pkg.
- REQ-022 SHALL implement multiply, saturating accumulate and the acc register in one sub-module neuron_mac; the top level adds the activation logic and the Out register.
- REQ-023 SHALL be written for synthesis, with no latches and with exactly two register groups: acc and Out.

Verification (WIDTH=8, clk period 10 ns, inputs driven away from the rising edge)
- REQ-024 SHALL cover negative accumulation: reset, then en=1 with (W,X)=(-3,2) then (5,-4) -> acc = -6 then -26, and Out = 0 after each edge.
- REQ-025 SHALL cover mid-operation reset: from acc=-26, assert rst=1 for one edge -> acc = 0 and Out = 0; after release, en=1 with W=X=0 -> Out stays 0.
- REQ-026 SHALL cover positive accumulation with latency: en=1 with (64,2) twice -> after the first edge Out = 0 (acc 128), after the second edge Out = 1.
- REQ-027 SHALL cover enable hold: en=0 with (8,4) for 3 edges -> acc stays 256 and Out stays 1.
- REQ-028 SHALL cover saturation: en=1 with (-128,-128) repeatedly -> acc clamps at 2^23-1 without wrapping, and Out remains 1.
- REQ-029 SHALL cover the zero boundary: accumulate (1,1) then (-1,1) -> Out = 1 one edge after acc = 1, and Out = 0 one edge after acc returns to 0.
